// File: rtl/integer_reservation_station.sv
// ---------------------------------------------------------------------------
// integer_reservation_station
//
// Integer issue queue that sits between dispatch and the integer execution
// block. It holds dispatched instructions until both source operands are
// available, snoops the common data bus (CDB) for missing operands, and
// presents the oldest ready entry to the execution block.
//
// Entries are kept compacted in age order (index 0 = oldest). An issued
// entry is removed and all younger entries shift down by one slot.
//
// Ports:
//   clk                    rising-edge clock
//   reset                  asynchronous, active-low reset
//   dispatch_enable        write one instruction this cycle
//   dispatch_opcode        integer opcode
//   dispatch_rd_tag        destination rename tag
//   dispatch_rs1_data/tag/data_val   first source operand, tag, valid flag
//   dispatch_rs2_data/tag/data_val   second source operand, tag, valid flag
//   cdb_valid/tag/data     common data bus broadcast
//   issueblk_done          execution block accepts the presented entry
//   issueque_full          all DEPTH entries occupied
//   issueque_ready         a ready entry is presented on the outputs below
//   issueque_opcode/rd_tag/rs1_data/rs2_data   presented entry fields
// ---------------------------------------------------------------------------
module integer_reservation_station #(
   parameter int DEPTH        = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int TAG_WIDTH    = 6,
   parameter int OPCODE_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    dispatch_enable,
   input  logic [OPCODE_WIDTH-1:0] dispatch_opcode,
   input  logic [TAG_WIDTH-1:0]    dispatch_rd_tag,
   input  logic [DATA_WIDTH-1:0]   dispatch_rs1_data,
   input  logic [TAG_WIDTH-1:0]    dispatch_rs1_tag,
   input  logic                    dispatch_rs1_data_val,
   input  logic [DATA_WIDTH-1:0]   dispatch_rs2_data,
   input  logic [TAG_WIDTH-1:0]    dispatch_rs2_tag,
   input  logic                    dispatch_rs2_data_val,
   input  logic                    cdb_valid,
   input  logic [TAG_WIDTH-1:0]    cdb_tag,
   input  logic [DATA_WIDTH-1:0]   cdb_data,
   input  logic                    issueblk_done,
   output logic                    issueque_full,
   output logic                    issueque_ready,
   output logic [OPCODE_WIDTH-1:0] issueque_opcode,
   output logic [TAG_WIDTH-1:0]    issueque_rd_tag,
   output logic [DATA_WIDTH-1:0]   issueque_rs1_data,
   output logic [DATA_WIDTH-1:0]   issueque_rs2_data
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Control state (reset)
   logic [DEPTH-1:0] valid_q,   valid_d;
   logic [DEPTH-1:0] rs1_vld_q, rs1_vld_d;
   logic [DEPTH-1:0] rs2_vld_q, rs2_vld_d;

   // Payload state (not reset; only observed through valid entries)
   logic [OPCODE_WIDTH-1:0] opcode_q   [DEPTH];
   logic [OPCODE_WIDTH-1:0] opcode_d   [DEPTH];
   logic [TAG_WIDTH-1:0]    rd_tag_q   [DEPTH];
   logic [TAG_WIDTH-1:0]    rd_tag_d   [DEPTH];
   logic [TAG_WIDTH-1:0]    rs1_tag_q  [DEPTH];
   logic [TAG_WIDTH-1:0]    rs1_tag_d  [DEPTH];
   logic [DATA_WIDTH-1:0]   rs1_data_q [DEPTH];
   logic [DATA_WIDTH-1:0]   rs1_data_d [DEPTH];
   logic [TAG_WIDTH-1:0]    rs2_tag_q  [DEPTH];
   logic [TAG_WIDTH-1:0]    rs2_tag_d  [DEPTH];
   logic [DATA_WIDTH-1:0]   rs2_data_q [DEPTH];
   logic [DATA_WIDTH-1:0]   rs2_data_d [DEPTH];

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] wr_ptr;
   logic [DEPTH-1:0] ready_vec;
   logic [IDX_W-1:0] sel;
   logic             any_ready;
   logic             full;
   logic             issue_fire;
   logic             dispatch_ok;

   // Occupancy from registered valid bits; entries are compacted so the
   // occupied slots are always 0..cnt-1.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt = cnt + CNT_W'(valid_q[i]);
      end
   end

   assign full      = (cnt == CNT_W'(DEPTH));
   assign ready_vec = valid_q & rs1_vld_q & rs2_vld_q;
   assign any_ready = |ready_vec;

   // Oldest ready entry wins: scan from youngest to oldest so the lowest
   // index is the last one assigned.
   always_comb begin
      sel = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ready_vec[i]) begin
            sel = IDX_W'(i);
         end
      end
   end

   assign issue_fire  = any_ready & issueblk_done;
   // Full is judged on registered state, so a removal on the same edge does
   // not open a slot for this dispatch.
   assign dispatch_ok = dispatch_enable & ~full;
   assign wr_ptr      = cnt - CNT_W'(issue_fire);

   // Next state: remove/compact, then CDB capture, then append.
   always_comb begin
      valid_d    = valid_q;
      rs1_vld_d  = rs1_vld_q;
      rs2_vld_d  = rs2_vld_q;
      opcode_d   = opcode_q;
      rd_tag_d   = rd_tag_q;
      rs1_tag_d  = rs1_tag_q;
      rs1_data_d = rs1_data_q;
      rs2_tag_d  = rs2_tag_q;
      rs2_data_d = rs2_data_q;

      if (issue_fire) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i >= int'(sel)) begin
               if (i < DEPTH - 1) begin
                  valid_d[i]    = valid_q[i+1];
                  rs1_vld_d[i]  = rs1_vld_q[i+1];
                  rs2_vld_d[i]  = rs2_vld_q[i+1];
                  opcode_d[i]   = opcode_q[i+1];
                  rd_tag_d[i]   = rd_tag_q[i+1];
                  rs1_tag_d[i]  = rs1_tag_q[i+1];
                  rs1_data_d[i] = rs1_data_q[i+1];
                  rs2_tag_d[i]  = rs2_tag_q[i+1];
                  rs2_data_d[i] = rs2_data_q[i+1];
               end else begin
                  valid_d[i]   = 1'b0;
                  rs1_vld_d[i] = 1'b0;
                  rs2_vld_d[i] = 1'b0;
               end
            end
         end
      end

      if (cdb_valid) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_d[i] && !rs1_vld_d[i] && (rs1_tag_d[i] == cdb_tag)) begin
               rs1_vld_d[i]  = 1'b1;
               rs1_data_d[i] = cdb_data;
            end
            if (valid_d[i] && !rs2_vld_d[i] && (rs2_tag_d[i] == cdb_tag)) begin
               rs2_vld_d[i]  = 1'b1;
               rs2_data_d[i] = cdb_data;
            end
         end
      end

      if (dispatch_ok) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (int'(wr_ptr) == i) begin
               valid_d[i]   = 1'b1;
               opcode_d[i]  = dispatch_opcode;
               rd_tag_d[i]  = dispatch_rd_tag;
               rs1_tag_d[i] = dispatch_rs1_tag;
               rs2_tag_d[i] = dispatch_rs2_tag;
               // Operand arriving on the CDB this very edge is bypassed in.
               if (dispatch_rs1_data_val) begin
                  rs1_vld_d[i]  = 1'b1;
                  rs1_data_d[i] = dispatch_rs1_data;
               end else if (cdb_valid && (cdb_tag == dispatch_rs1_tag)) begin
                  rs1_vld_d[i]  = 1'b1;
                  rs1_data_d[i] = cdb_data;
               end else begin
                  rs1_vld_d[i]  = 1'b0;
                  rs1_data_d[i] = dispatch_rs1_data;
               end
               if (dispatch_rs2_data_val) begin
                  rs2_vld_d[i]  = 1'b1;
                  rs2_data_d[i] = dispatch_rs2_data;
               end else if (cdb_valid && (cdb_tag == dispatch_rs2_tag)) begin
                  rs2_vld_d[i]  = 1'b1;
                  rs2_data_d[i] = cdb_data;
               end else begin
                  rs2_vld_d[i]  = 1'b0;
                  rs2_data_d[i] = dispatch_rs2_data;
               end
            end
         end
      end
   end

   // Control registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q   <= '0;
         rs1_vld_q <= '0;
         rs2_vld_q <= '0;
      end else begin
         valid_q   <= valid_d;
         rs1_vld_q <= rs1_vld_d;
         rs2_vld_q <= rs2_vld_d;
      end
   end

   // Payload registers
   always_ff @(posedge clk) begin
      opcode_q   <= opcode_d;
      rd_tag_q   <= rd_tag_d;
      rs1_tag_q  <= rs1_tag_d;
      rs1_data_q <= rs1_data_d;
      rs2_tag_q  <= rs2_tag_d;
      rs2_data_q <= rs2_data_d;
   end

   // Issue outputs are forced to zero when nothing is ready.
   assign issueque_full     = full;
   assign issueque_ready    = any_ready;
   assign issueque_opcode   = any_ready ? opcode_q[sel]   : '0;
   assign issueque_rd_tag   = any_ready ? rd_tag_q[sel]   : '0;
   assign issueque_rs1_data = any_ready ? rs1_data_q[sel] : '0;
   assign issueque_rs2_data = any_ready ? rs2_data_q[sel] : '0;

endmodule

// File: tb/tb_integer_reservation_station.sv
module tb_integer_reservation_station;

   logic        clk = 1'b0;
   logic        reset;
   logic        dispatch_enable;
   logic [3:0]  dispatch_opcode;
   logic [5:0]  dispatch_rd_tag;
   logic [31:0] dispatch_rs1_data;
   logic [5:0]  dispatch_rs1_tag;
   logic        dispatch_rs1_data_val;
   logic [31:0] dispatch_rs2_data;
   logic [5:0]  dispatch_rs2_tag;
   logic        dispatch_rs2_data_val;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        issueblk_done;
   logic        issueque_full;
   logic        issueque_ready;
   logic [3:0]  issueque_opcode;
   logic [5:0]  issueque_rd_tag;
   logic [31:0] issueque_rs1_data;
   logic [31:0] issueque_rs2_data;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   integer_reservation_station #(
      .DEPTH(4), .DATA_WIDTH(32), .TAG_WIDTH(6), .OPCODE_WIDTH(4)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .dispatch_enable       (dispatch_enable),
      .dispatch_opcode       (dispatch_opcode),
      .dispatch_rd_tag       (dispatch_rd_tag),
      .dispatch_rs1_data     (dispatch_rs1_data),
      .dispatch_rs1_tag      (dispatch_rs1_tag),
      .dispatch_rs1_data_val (dispatch_rs1_data_val),
      .dispatch_rs2_data     (dispatch_rs2_data),
      .dispatch_rs2_tag      (dispatch_rs2_tag),
      .dispatch_rs2_data_val (dispatch_rs2_data_val),
      .cdb_valid             (cdb_valid),
      .cdb_tag               (cdb_tag),
      .cdb_data              (cdb_data),
      .issueblk_done         (issueblk_done),
      .issueque_full         (issueque_full),
      .issueque_ready        (issueque_ready),
      .issueque_opcode       (issueque_opcode),
      .issueque_rd_tag       (issueque_rd_tag),
      .issueque_rs1_data     (issueque_rs1_data),
      .issueque_rs2_data     (issueque_rs2_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [3:0] op, input logic [5:0] rd,
                       input logic [31:0] d1, input logic [5:0] t1, input logic v1,
                       input logic [31:0] d2, input logic [5:0] t2, input logic v2);
      dispatch_enable       = 1'b1;
      dispatch_opcode       = op;
      dispatch_rd_tag       = rd;
      dispatch_rs1_data     = d1;
      dispatch_rs1_tag      = t1;
      dispatch_rs1_data_val = v1;
      dispatch_rs2_data     = d2;
      dispatch_rs2_tag      = t2;
      dispatch_rs2_data_val = v2;
   endtask

   task automatic cdb(input logic [5:0] t, input logic [31:0] d);
      cdb_valid = 1'b1;
      cdb_tag   = t;
      cdb_data  = d;
   endtask

   task automatic idle();
      dispatch_enable = 1'b0;
      cdb_valid       = 1'b0;
   endtask

   initial begin
      // Reset held with a ready dispatch pending: nothing may enter.
      reset         = 1'b0;
      issueblk_done = 1'b0;
      cdb_valid     = 1'b0;
      cdb_tag       = '0;
      cdb_data      = '0;
      disp(4'h9, 6'd1, 32'h11, 6'd0, 1'b1, 32'h22, 6'd0, 1'b1);
      step();
      step();
      chk("rst_full",  issueque_full,     0);
      chk("rst_ready", issueque_ready,    0);
      chk("rst_op",    issueque_opcode,   0);
      chk("rst_rd",    issueque_rd_tag,   0);
      chk("rst_rs1",   issueque_rs1_data, 0);
      chk("rst_rs2",   issueque_rs2_data, 0);
      idle();
      reset = 1'b1;
      step();
      chk("post_rst_ready", issueque_ready, 0);
      chk("post_rst_full",  issueque_full,  0);

      // Ready dispatch: visible one cycle later, removed the cycle after.
      issueblk_done = 1'b1;
      disp(4'h3, 6'd10, 32'h5, 6'd0, 1'b1, 32'h7, 6'd0, 1'b1);
      step();
      idle();
      chk("rd_ready", issueque_ready,    1);
      chk("rd_op",    issueque_opcode,   4'h3);
      chk("rd_rd",    issueque_rd_tag,   6'd10);
      chk("rd_rs1",   issueque_rs1_data, 32'h5);
      chk("rd_rs2",   issueque_rs2_data, 32'h7);
      step();
      chk("rd_gone", issueque_ready, 0);

      // Dependency wakeup through the CDB.
      disp(4'h1, 6'd11, 32'h0, 6'd20, 1'b0, 32'h2, 6'd0, 1'b1);
      step();
      idle();
      chk("wk_wait", issueque_ready, 0);
      cdb(6'd20, 32'hDEAD);
      step();
      idle();
      chk("wk_ready", issueque_ready,    1);
      chk("wk_rd",    issueque_rd_tag,   6'd11);
      chk("wk_rs1",   issueque_rs1_data, 32'hDEAD);
      chk("wk_rs2",   issueque_rs2_data, 32'h2);
      step();
      chk("wk_gone", issueque_ready, 0);

      // Out-of-order issue: younger B overtakes waiting A.
      issueblk_done = 1'b0;
      disp(4'h2, 6'd12, 32'h0, 6'd21, 1'b0, 32'h1, 6'd0, 1'b1);
      step();
      disp(4'h4, 6'd13, 32'h8, 6'd0, 1'b1, 32'h9, 6'd0, 1'b1);
      step();
      idle();
      chk("ooo_b_ready", issueque_ready,  1);
      chk("ooo_b_rd",    issueque_rd_tag, 6'd13);
      chk("ooo_b_op",    issueque_opcode, 4'h4);
      issueblk_done = 1'b1;
      step();
      issueblk_done = 1'b0;
      chk("ooo_a_wait", issueque_ready, 0);
      cdb(6'd21, 32'h55);
      step();
      idle();
      chk("ooo_a_rd",  issueque_rd_tag,   6'd12);
      chk("ooo_a_rs1", issueque_rs1_data, 32'h55);
      issueblk_done = 1'b1;
      step();
      chk("ooo_empty", issueque_ready, 0);

      // Fill the queue with waiting entries rd 20..23 (rs1 tags 30..33).
      issueblk_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         disp(4'h5, 6'(20 + k), 32'h0, 6'(30 + k), 1'b0, 32'(k), 6'd0, 1'b1);
         step();
      end
      chk("full_set",   issueque_full,  1);
      chk("full_nordy", issueque_ready, 0);
      // Fifth (ready) dispatch must be dropped.
      disp(4'h6, 6'd24, 32'h1, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1);
      step();
      idle();
      chk("full_drop_ready", issueque_ready, 0);
      chk("full_drop_full",  issueque_full,  1);
      cdb(6'd31, 32'hABC);
      step();
      idle();
      chk("full_wk_rd",   issueque_rd_tag,   6'd21);
      chk("full_wk_rs1",  issueque_rs1_data, 32'hABC);
      chk("full_wk_rs2",  issueque_rs2_data, 32'h1);
      chk("full_wk_full", issueque_full,     1);
      // Issue while dispatching: the dispatch sees full and is ignored.
      issueblk_done = 1'b1;
      disp(4'h7, 6'd25, 32'h1, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1);
      step();
      idle();
      issueblk_done = 1'b0;
      chk("full_rel",     issueque_full,  0);
      chk("full_noearly", issueque_ready, 0);

      // Queue: 20,22,23. Add 26 waiting on tag 50 -> full again.
      disp(4'h8, 6'd26, 32'h0, 6'd50, 1'b0, 32'h4, 6'd0, 1'b1);
      step();
      idle();
      cdb(6'd30, 32'h1);
      step();
      idle();
      chk("sim_pre_rd",   issueque_rd_tag, 6'd20);
      chk("sim_pre_full", issueque_full,   1);
      // Issue 20 and wake 26 on the same edge.
      issueblk_done = 1'b1;
      cdb(6'd50, 32'h77);
      step();
      idle();
      chk("sim1_rd",   issueque_rd_tag,   6'd26);
      chk("sim1_rs1",  issueque_rs1_data, 32'h77);
      chk("sim1_full", issueque_full,     0);
      // Issue 26, wake 22, and dispatch 27 needing tag 32 (bypass) together.
      cdb(6'd32, 32'h99);
      disp(4'hA, 6'd27, 32'h0, 6'd32, 1'b0, 32'h3, 6'd0, 1'b1);
      step();
      idle();
      chk("sim2_rd",  issueque_rd_tag,   6'd22);
      chk("sim2_rs1", issueque_rs1_data, 32'h99);
      chk("sim2_rs2", issueque_rs2_data, 32'h2);
      step();
      chk("byp_rd",  issueque_rd_tag,   6'd27);
      chk("byp_op",  issueque_opcode,   4'hA);
      chk("byp_rs1", issueque_rs1_data, 32'h99);
      chk("byp_rs2", issueque_rs2_data, 32'h3);
      step();
      chk("byp_gone", issueque_ready, 0);

      // Stall: remaining entry 23 held for three cycles.
      issueblk_done = 1'b0;
      cdb(6'd33, 32'h5);
      step();
      idle();
      for (int k = 0; k < 3; k++) begin
         chk("stall_ready", issueque_ready,    1);
         chk("stall_rd",    issueque_rd_tag,   6'd23);
         chk("stall_rs1",   issueque_rs1_data, 32'h5);
         step();
      end
      issueblk_done = 1'b1;
      step();
      chk("stall_gone", issueque_ready, 0);

      // Asynchronous reset mid-operation discards the queue immediately.
      disp(4'hC, 6'd40, 32'h1, 6'd0, 1'b1, 32'h2, 6'd0, 1'b1);
      issueblk_done = 1'b0;
      step();
      idle();
      chk("mid_ready", issueque_ready, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_ready", issueque_ready,  0);
      chk("async_rd",    issueque_rd_tag, 0);
      step();
      reset = 1'b1;
      step();
      chk("async_empty", issueque_ready, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
